// File: rtl/n_bit_updown_mod_counter.sv
// WIDTH-bit modulo counter with programmable bound, up/down/ping-pong/hold modes,
// synchronous clamped load, wrap or saturate policy and a registered boundary pulse.
module n_bit_updown_mod_counter #(
    parameter int WIDTH     = 3,
    parameter int MAX_COUNT = 2**WIDTH-1,
    parameter bit SATURATE  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);

    localparam logic [1:0] MODE_UP   = 2'b00;
    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_PP   = 2'b10;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_t;

    dir_t             dir_q;
    dir_t             dir_d;
    logic [WIDTH-1:0] count_d;
    logic             tc_d;

    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
        return (v > MAX_V) ? MAX_V : v;
    endfunction

    assign dir_q = dir_t'(dir);

    always_comb begin
        count_d = count;
        dir_d   = dir_q;
        tc_d    = 1'b0;
        if (load) begin
            count_d = clamp_load(load_val);
        end else begin
            // Up/down modes force the direction flag even while disabled.
            if (mode == MODE_UP)   dir_d = UP;
            if (mode == MODE_DOWN) dir_d = DOWN;
            if (en && mode != MODE_HOLD) begin
                case (mode)
                    MODE_UP: begin
                        if (count < MAX_V) begin
                            count_d = count + 1'b1;
                        end else begin
                            tc_d = 1'b1;
                            if (!SATURATE) count_d = '0;
                        end
                    end
                    MODE_DOWN: begin
                        if (count != '0) begin
                            count_d = count - 1'b1;
                        end else begin
                            tc_d = 1'b1;
                            if (!SATURATE) count_d = MAX_V;
                        end
                    end
                    MODE_PP: begin
                        // Reflect at either end without dwelling on the boundary value.
                        if (dir_q == UP) begin
                            if (count < MAX_V) begin
                                count_d = count + 1'b1;
                            end else begin
                                count_d = MAX_V - 1'b1;
                                dir_d   = DOWN;
                                tc_d    = 1'b1;
                            end
                        end else begin
                            if (count != '0) begin
                                count_d = count - 1'b1;
                            end else begin
                                count_d = WIDTH'(1);
                                dir_d   = UP;
                                tc_d    = 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            dir   <= 1'b0;
            tc    <= 1'b0;
        end else begin
            count <= count_d;
            dir   <= dir_d;
            tc    <= tc_d;
        end
    end

endmodule

// File: tb/tb_n_bit_updown_mod_counter.sv
// Bench for n_bit_updown_mod_counter: wrap and saturate instances driven in parallel,
// checked against vector tables, hand-written sequences and an arithmetic reference model.
module tb_n_bit_updown_mod_counter;

    localparam int W   = 3;
    localparam int MAX = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [1:0]   mode;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] count0, count1;
    logic         dir0, dir1, tc0, tc1;

    n_bit_updown_mod_counter #(.WIDTH(W), .MAX_COUNT(MAX), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .load_val(load_val),
        .count(count0), .dir(dir0), .tc(tc0)
    );

    n_bit_updown_mod_counter #(.WIDTH(W), .MAX_COUNT(MAX), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .load_val(load_val),
        .count(count1), .dir(dir1), .tc(tc1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state per instance: index 0 wraps, index 1 saturates.
    int mc[2];
    int mdir[2];
    int mtc[2];

    typedef struct {
        int ld; int en; int md; int lv;
        int ec; int ed; int et;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(int ld, int e, int md, int lv, int ec, int ed, int et);
        vec_t v;
        v.ld = ld; v.en = e; v.md = md; v.lv = lv;
        v.ec = ec; v.ed = ed; v.et = et;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            mc[i] = 0; mdir[i] = 0; mtc[i] = 0;
        end
    endfunction

    // Counting treated as a signed velocity on 0..MAX: leaving the range either
    // wraps modulo MAX+1, sticks, or reflects, depending on mode and policy.
    function automatic void model_step(int i, int l, int e, int m, int v);
        int step, nxt;
        if (l != 0) begin
            mc[i]  = (v > MAX) ? MAX : v;
            mtc[i] = 0;
            return;
        end
        if (m == 0) mdir[i] = 0;
        if (m == 1) mdir[i] = 1;
        if (e == 0 || m == 3) begin
            mtc[i] = 0;
            return;
        end
        step = (m == 0) ? 1 : (m == 1) ? -1 : (mdir[i] != 0 ? -1 : 1);
        nxt  = mc[i] + step;
        if (nxt >= 0 && nxt <= MAX) begin
            mc[i]  = nxt;
            mtc[i] = 0;
        end else begin
            mtc[i] = 1;
            if (m == 2) begin
                mdir[i] = 1 - mdir[i];
                mc[i]   = mc[i] - step;
            end else if (i == 0) begin
                mc[i] = (nxt + MAX + 1) % (MAX + 1);
            end
        end
    endfunction

    task automatic tick();
        int l, e, m, v;
        l = int'(load); e = int'(en); m = int'(mode); v = int'(load_val);
        @(posedge clk);
        #1;
        model_step(0, l, e, m, v);
        model_step(1, l, e, m, v);
        chk("mdl_cnt_wrap", int'(count0), mc[0]);
        chk("mdl_dir_wrap", int'(dir0),   mdir[0]);
        chk("mdl_tc_wrap",  int'(tc0),    mtc[0]);
        chk("mdl_cnt_sat",  int'(count1), mc[1]);
        chk("mdl_dir_sat",  int'(dir1),   mdir[1]);
        chk("mdl_tc_sat",   int'(tc1),    mtc[1]);
    endtask

    task automatic drive(input int l, input int e, input int m, input int v);
        load = l[0]; en = e[0]; mode = m[1:0]; load_val = v[W-1:0];
    endtask

    initial begin
        int pp_c[12];
        int pp_d[12];
        int pp_t[12];
        int sat_c[4];
        int sat_t[4];

        rst = 1'b0;
        drive(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cnt", int'(count0), 0);
        chk("rst_dir", int'(dir0), 0);
        chk("rst_tc",  int'(tc0), 0);
        chk("rst_cnt_sat", int'(count1), 0);
        rst = 1'b1;
        model_reset();

        // Wrap instance vectors: up wrap, clamped load, dir under en=0, hold, down wrap, ping-pong turnaround.
        tv.push_back(mk(0,1,0,0, 1,0,0));
        tv.push_back(mk(0,1,0,0, 2,0,0));
        tv.push_back(mk(0,1,0,0, 3,0,0));
        tv.push_back(mk(0,1,0,0, 4,0,0));
        tv.push_back(mk(0,1,0,0, 5,0,0));
        tv.push_back(mk(0,1,0,0, 0,0,1));
        tv.push_back(mk(0,1,0,0, 1,0,0));
        tv.push_back(mk(1,1,0,7, 5,0,0));
        tv.push_back(mk(0,1,1,0, 4,1,0));
        tv.push_back(mk(0,0,0,0, 4,0,0));
        tv.push_back(mk(0,0,1,0, 4,1,0));
        tv.push_back(mk(0,1,3,0, 4,1,0));
        tv.push_back(mk(0,1,1,0, 3,1,0));
        tv.push_back(mk(0,1,1,0, 2,1,0));
        tv.push_back(mk(0,1,1,0, 1,1,0));
        tv.push_back(mk(0,1,1,0, 0,1,0));
        tv.push_back(mk(0,1,1,0, 5,1,1));
        tv.push_back(mk(0,1,1,0, 4,1,0));
        tv.push_back(mk(1,0,2,0, 0,1,0));
        tv.push_back(mk(0,1,2,0, 1,0,1));
        tv.push_back(mk(0,1,2,0, 2,0,0));
        tv.push_back(mk(1,1,2,6, 5,0,0));
        for (int k = 0; k < tv.size(); k++) begin
            drive(tv[k].ld, tv[k].en, tv[k].md, tv[k].lv);
            tick();
            chk($sformatf("tbl%0d_cnt", k), int'(count0), tv[k].ec);
            chk($sformatf("tbl%0d_dir", k), int'(dir0),   tv[k].ed);
            chk($sformatf("tbl%0d_tc", k),  int'(tc0),    tv[k].et);
        end

        // Asynchronous reset in mid-count, then resume from zero.
        drive(1, 0, 0, 4);
        tick();
        chk("pre_rst_cnt", int'(count0), 4);
        drive(0, 1, 0, 0);
        #3;
        rst = 1'b0;
        #1;
        chk("async_rst_cnt", int'(count0), 0);
        chk("async_rst_dir", int'(dir0), 0);
        chk("async_rst_tc",  int'(tc0), 0);
        @(posedge clk);
        #1;
        chk("rst_held_cnt", int'(count0), 0);
        rst = 1'b1;
        model_reset();
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("post_rst_cnt%0d", k), int'(count0), k);
        end

        // Saturating instance: climb to the top and stick, then descend.
        sat_c = '{4, 5, 5, 5};
        sat_t = '{0, 0, 1, 1};
        drive(1, 0, 0, 3);
        tick();
        drive(0, 1, 0, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("sat_up%0d_cnt", k), int'(count1), sat_c[k]);
            chk($sformatf("sat_up%0d_tc", k),  int'(tc1),    sat_t[k]);
        end
        drive(0, 1, 1, 0);
        tick();
        chk("sat_dn0_cnt", int'(count1), 4);
        chk("sat_dn0_tc",  int'(tc1), 0);
        tick();
        chk("sat_dn1_cnt", int'(count1), 3);
        chk("sat_dn1_tc",  int'(tc1), 0);

        // Ping-pong from 0 with dir up; policy must not matter.
        drive(0, 0, 0, 0);
        tick();
        drive(1, 1, 2, 0);
        tick();
        pp_c = '{1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 1, 2};
        pp_d = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0};
        pp_t = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
        drive(0, 1, 2, 0);
        for (int k = 0; k < 12; k++) begin
            tick();
            chk($sformatf("pp%0d_cnt", k), int'(count0), pp_c[k]);
            chk($sformatf("pp%0d_dir", k), int'(dir0),   pp_d[k]);
            chk($sformatf("pp%0d_tc", k),  int'(tc0),    pp_t[k]);
            chk($sformatf("pp%0d_cnt_sat", k), int'(count1), pp_c[k]);
        end

        // Load while ping-ponging downward keeps the direction.
        drive(0, 0, 1, 0);
        tick();
        drive(1, 1, 2, 2);
        tick();
        chk("ppld_cnt", int'(count0), 2);
        chk("ppld_dir", int'(dir0), 1);
        chk("ppld_tc",  int'(tc0), 0);
        drive(0, 1, 2, 0);
        tick();
        chk("ppld_next_cnt", int'(count0), 1);
        chk("ppld_next_dir", int'(dir0), 1);

        // Hold via mode 11, then via en = 0, then dir forced by mode 01 while disabled.
        drive(1, 0, 0, 3);
        tick();
        for (int k = 0; k < 8; k++) begin
            drive(0, (k < 4) ? 1 : 0, (k < 4) ? 3 : 0, 0);
            tick();
            chk($sformatf("hold%0d_cnt", k), int'(count0), 3);
            chk($sformatf("hold%0d_tc", k),  int'(tc0), 0);
        end
        drive(0, 0, 1, 0);
        tick();
        chk("dis_dn_dir", int'(dir0), 1);
        chk("dis_dn_cnt", int'(count0), 3);

        // Random traffic against the reference model.
        for (int k = 0; k < 400; k++) begin
            drive(($urandom_range(7, 0) == 0) ? 1 : 0,
                  ($urandom_range(3, 0) != 0) ? 1 : 0,
                  int'($urandom_range(3, 0)),
                  int'($urandom_range(7, 0)));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/n_bit_updown_mod_counter.md
# n_bit_updown_mod_counter

Parametrised successor to the N-bit up counter: a WIDTH-bit modulo counter with a programmable upper bound, four run modes (up, down, ping-pong, hold), synchronous parallel load, count enable and a selectable wrap/saturate policy. It flags every boundary event with a one-cycle terminal-count pulse. It sits wherever the design needs a sequencing, timeout or address counter that the plain up counter cannot cover.

## Interface

- WIDTH, 3, counter width in bits; WIDTH >= 2
- MAX_COUNT, 2**WIDTH-1, inclusive upper bound; 1 <= MAX_COUNT <= 2**WIDTH-1
- SATURATE, 0, 0 = wrap at boundaries, 1 = hold at boundaries (up/down modes only)

- clk  input  1  rising-edge clock, the only clock
- rst  input  1  asynchronous, active-low reset
- en  input  1  count enable; one step per rising edge while high
- mode  input  2  00 up, 01 down, 10 ping-pong, 11 hold
- load  input  1  synchronous parallel load; overrides en
- load_val  input  WIDTH  load value; values above MAX_COUNT are clamped to MAX_COUNT
- count  output  WIDTH  registered count, always in 0..MAX_COUNT
- dir  output  1  registered direction, 0 = up, 1 = down
- tc  output  1  registered one-cycle pulse marking a boundary event

## Operation

- rst low: count = 0, dir = 0, tc = 0 immediately, independent of clk. Release takes effect at the next rising edge.
- Per-edge priority: load, then hold/!en, then mode step.
- load = 1: count <= min(load_val, MAX_COUNT). dir is unchanged and tc <= 0, whatever en and mode are.
- mode 11, or en = 0, with no load: count holds and tc <= 0.
- dir register:
  - dir <= 0 on every edge with mode 00; dir <= 1 on every edge with mode 01. This holds even when en = 0.
  - dir holds in mode 11.
  - In mode 10 dir toggles only at a turnaround.
- Up step (mode 00, en):
  - count < MAX_COUNT: count + 1.
  - count == MAX_COUNT: becomes 0 if SATURATE = 0, else holds. tc <= 1 in both cases.
- Down step (mode 01, en):
  - count > 0: count - 1.
  - count == 0: becomes MAX_COUNT if SATURATE = 0, else holds. tc <= 1 in both cases.
- Ping-pong step (mode 10, en), a two-state machine on dir:
  - UP (dir = 0): count + 1 while count < MAX_COUNT. At count == MAX_COUNT: count <= MAX_COUNT-1, dir <= 1, tc <= 1.
  - DOWN (dir = 1): count - 1 while count > 0. At count == 0: count <= 1, dir <= 0, tc <= 1.
  - No dwell at the ends. SATURATE is ignored.
- All non-boundary steps: tc <= 0.
- Arithmetic is WIDTH bits and never leaves 0..MAX_COUNT. No overflow into unused codes when MAX_COUNT < 2**WIDTH-1.
- Mode changes mid-count take effect on the same edge. Count continues from its current value.

## Timing

- Single clock domain. All outputs come straight from flops; no combinational input-to-output path.
- Latency: inputs sampled at edge N appear on count/dir/tc after edge N.
- tc is high for exactly the one cycle following the edge that performed the boundary event. It stays high continuously only in saturate mode while held at the boundary with en = 1.
- Reset asserted mid-count clears all outputs asynchronously. The first step after release is from 0 with dir = 0.

## Test plan

Use WIDTH = 3, MAX_COUNT = 5 unless noted.

- Reset: rst low mid-count (count = 4) -> count = 0, dir = 0, tc = 0 before the next edge. After release with mode 00, en = 1 -> 1, 2, 3.
- Up wrap, SATURATE = 0, mode 00, en held -> 0, 1, 2, 3, 4, 5, 0, 1. tc high only in the cycle count shows 0 after 5.
- Saturate, SATURATE = 1:
  - Mode 00 from 3 -> 4, 5, 5, 5 with tc = 1 from the first repeated 5.
  - Switch to mode 01 -> 4, 3 with tc = 0.
- Ping-pong from 0 with en high -> 1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 1, 2.
  - dir changes with the 5->4 step and with the 0->1 step.
  - tc pulses with the 5->4 step and with the 0->1 step.
- Load priority:
  - load = 1, en = 1, load_val = 7 -> count = 5 (clamped), tc = 0.
  - load_val = 2 in ping-pong with dir = 1 -> count = 2, dir stays 1, next step gives 1.
- Hold/enable: mode 11 or en = 0 for 4 cycles at count = 3 -> count stays 3, tc = 0. With en = 0, mode 01 still sets dir = 1.
